// File: rtl/fd_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : fd_queue_if
//  Description : Fetch->decode handshake bundle for fd_queue. The slave
//                modport is the queue; the master modport is the fetch /
//                decode environment driving it.
//  Revision    : 1.0  initial release
// ============================================================================
interface fd_queue_if #(
    parameter int CNT_W = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      PC_in;
    logic [31:0]      IR_in;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      PC_out;
    logic [31:0]      IR_out;
    logic [4:0]       opcode;
    logic [4:0]       rd;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [CNT_W-1:0] count;

    modport slave (
        input  in_valid, PC_in, IR_in, out_ready,
        output in_ready, out_valid, PC_out, IR_out, opcode, rd, rs, rt, count
    );

    modport master (
        output in_valid, PC_in, IR_in, out_ready,
        input  in_ready, out_valid, PC_out, IR_out, opcode, rd, rs, rt, count
    );
endinterface
`default_nettype wire

// File: rtl/fd_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fd_queue
//  Description : DEPTH-entry FIFO of {PC, IR} pairs between fetch and decode
//                with valid/ready handshakes, global stall (en), flush and
//                pre-split register fields of the head instruction.
//                Optional macro FD_BYPASS_EN: an empty queue forwards the
//                fetch inputs straight to the outputs in the same cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module fd_queue #(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic     clk,
    input  logic     clr,
    input  logic     en,
    input  logic     flush,
    fd_queue_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] c_PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wp_q, wp_d;
    logic [PTR_W-1:0] rp_q, rp_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      pc_mem_q [DEPTH];
    logic [31:0]      ir_mem_q [DEPTH];

    logic             w_empty;
    logic             w_bypass;
    logic             w_push;
    logic             w_pop;
    logic [31:0]      w_pc_out;
    logic [31:0]      w_ir_out;

    assign w_empty = (count_q == '0);

`ifdef FD_BYPASS_EN
    assign w_bypass = w_empty & bus.in_valid & ~flush;
`else
    assign w_bypass = 1'b0;
`endif

    // in_ready looks at count only: a full queue refuses a push even while popping.
    assign bus.in_ready  = (count_q != c_CNT_FULL);
    assign bus.out_valid = ~w_empty | w_bypass;

    // A bypassed instruction accepted by decode the same cycle is never stored.
    assign w_push = en & bus.in_valid & bus.in_ready & ~flush
                  & ~(w_bypass & bus.out_ready);
    // Pops come from storage only; the bypass path never advances rp.
    assign w_pop  = en & ~w_empty & bus.out_ready & ~flush;

    // Head selection: bypass input, stored head, or a forced-zero nop when empty.
    always_comb begin
        w_pc_out = '0;
        w_ir_out = '0;
        if (w_bypass) begin
            w_pc_out = bus.PC_in;
            w_ir_out = bus.IR_in;
        end else if (!w_empty) begin
            w_pc_out = pc_mem_q[rp_q];
            w_ir_out = ir_mem_q[rp_q];
        end
    end

    assign bus.PC_out = w_pc_out;
    assign bus.IR_out = w_ir_out;
    assign bus.opcode = w_ir_out[31:27];
    assign bus.rd     = w_ir_out[26:22];
    assign bus.rs     = w_ir_out[21:17];
    assign bus.rt     = w_ir_out[16:12];
    assign bus.count  = count_q;

    // Next pointer/count values; wrap by explicit compare so any DEPTH works.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (en) begin
            if (flush) begin
                wp_d    = '0;
                rp_d    = '0;
                count_d = '0;
            end else begin
                if (w_push) wp_d = (wp_q == c_PTR_LAST) ? '0 : wp_q + 1'b1;
                if (w_pop)  rp_d = (rp_q == c_PTR_LAST) ? '0 : rp_q + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
            end
        end
    end

    // Pointer and occupancy registers, cleared asynchronously by clr.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents persist after pop/flush and are hidden by count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            pc_mem_q[wp_q] <= bus.PC_in;
            ir_mem_q[wp_q] <= bus.IR_in;
        end
    end
endmodule
`default_nettype wire
